// File: rtl/urv_dm_arbiter.sv
// Data-memory port arbiter: the core is forwarded with zero latency, a secondary master gets a
// guaranteed slot through a starvation counter, and an optional timeout aborts stuck accesses.
module urv_dm_arbiter #(
  parameter int unsigned g_ext_max_wait = 8,
  parameter int unsigned g_timeout      = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_data_i,
  input  logic [3:0]  core_select_i,
  input  logic        core_load_i,
  input  logic        core_store_i,
  output logic        core_ready_o,
  output logic [31:0] core_data_o,
  output logic        core_err_o,
  input  logic [31:0] ext_addr_i,
  input  logic [31:0] ext_data_i,
  input  logic [3:0]  ext_select_i,
  input  logic        ext_we_i,
  input  logic        ext_req_i,
  output logic        ext_ack_o,
  output logic [31:0] ext_data_o,
  output logic        ext_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_select_o,
  output logic        mem_load_o,
  output logic        mem_store_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i
);
  typedef enum logic [1:0] {IDLE, CORE_WAIT, EXT} state_t;

  localparam logic [7:0]  MAX_WAIT = 8'(g_ext_max_wait);
  localparam logic [31:0] TMO_LAST = (g_timeout > 0) ? 32'(g_timeout - 1) : 32'd0;
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] tmo_cnt;
  logic [31:0] lat_addr, lat_data;
  logic [3:0]  lat_select;
  logic        lat_load, lat_store;

  logic core_req, grant_ext, grant_core, in_access, tmo_hit, done;

  assign core_req   = core_load_i | core_store_i;
  assign grant_ext  = (state == IDLE) && ext_req_i && (!core_req || wait_cnt == MAX_WAIT);
  assign grant_core = (state == IDLE) && core_req && !grant_ext;
  assign in_access  = grant_core || (state != IDLE);
  // The abort fires in the cycle the count would reach g_timeout, not the one after.
  assign tmo_hit    = (g_timeout > 0) && in_access && !mem_ready_i && (tmo_cnt == TMO_LAST);
  assign done       = in_access && (mem_ready_i || tmo_hit);

  always_comb begin
    mem_addr_o   = lat_addr;
    mem_data_o   = lat_data;
    mem_select_o = lat_select;
    mem_load_o   = 1'b0;
    mem_store_o  = 1'b0;
    core_ready_o = 1'b0;
    core_data_o  = tmo_hit ? ABORT_DATA : mem_data_i;
    core_err_o   = 1'b0;
    ext_ack_o    = 1'b0;
    ext_data_o   = tmo_hit ? ABORT_DATA : mem_data_i;
    ext_err_o    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_core) begin
          mem_addr_o   = core_addr_i;
          mem_data_o   = core_data_i;
          mem_select_o = core_select_i;
          mem_load_o   = core_load_i & !tmo_hit;
          mem_store_o  = core_store_i & !core_load_i & !tmo_hit;
          core_ready_o = mem_ready_i | tmo_hit;
          core_err_o   = tmo_hit;
        end else begin
          // Idle port reports ready; a core request losing to ext stalls.
          core_ready_o = !core_req;
        end
      end
      CORE_WAIT: begin
        mem_load_o   = lat_load & !tmo_hit;
        mem_store_o  = lat_store & !tmo_hit;
        core_ready_o = mem_ready_i | tmo_hit;
        core_err_o   = tmo_hit;
      end
      EXT: begin
        mem_load_o  = lat_load & !tmo_hit;
        mem_store_o = lat_store & !tmo_hit;
        ext_ack_o   = mem_ready_i | tmo_hit;
        ext_err_o   = tmo_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_select <= '0;
      lat_load   <= 1'b0;
      lat_store  <= 1'b0;
    end else begin
      if (state == EXT && done)
        wait_cnt <= '0;
      else if (ext_req_i && state != EXT && wait_cnt != MAX_WAIT)
        wait_cnt <= wait_cnt + 8'd1;

      if (done)
        tmo_cnt <= '0;
      else if (in_access && !mem_ready_i)
        tmo_cnt <= tmo_cnt + 32'd1;

      case (state)
        IDLE: begin
          if (grant_ext) begin
            lat_addr   <= ext_addr_i;
            lat_data   <= ext_data_i;
            lat_select <= ext_select_i;
            lat_load   <= !ext_we_i;
            lat_store  <= ext_we_i;
            state      <= EXT;
          end else if (grant_core && !done) begin
            lat_addr   <= core_addr_i;
            lat_data   <= core_data_i;
            lat_select <= core_select_i;
            lat_load   <= core_load_i;
            lat_store  <= core_store_i & !core_load_i;
            state      <= CORE_WAIT;
          end
        end
        CORE_WAIT, EXT: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Directed bench for urv_dm_arbiter (g_ext_max_wait=8, g_timeout=4).
module tb_urv_dm_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] core_addr_i, core_data_i;
  logic [3:0]  core_select_i;
  logic        core_load_i, core_store_i;
  logic        core_ready_o, core_err_o;
  logic [31:0] core_data_o;
  logic [31:0] ext_addr_i, ext_data_i;
  logic [3:0]  ext_select_i;
  logic        ext_we_i, ext_req_i;
  logic        ext_ack_o, ext_err_o;
  logic [31:0] ext_data_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [3:0]  mem_select_o;
  logic        mem_load_o, mem_store_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  urv_dm_arbiter #(.g_ext_max_wait(8), .g_timeout(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_addr_i(core_addr_i), .core_data_i(core_data_i), .core_select_i(core_select_i),
    .core_load_i(core_load_i), .core_store_i(core_store_i),
    .core_ready_o(core_ready_o), .core_data_o(core_data_o), .core_err_o(core_err_o),
    .ext_addr_i(ext_addr_i), .ext_data_i(ext_data_i), .ext_select_i(ext_select_i),
    .ext_we_i(ext_we_i), .ext_req_i(ext_req_i),
    .ext_ack_o(ext_ack_o), .ext_data_o(ext_data_o), .ext_err_o(ext_err_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_select_o(mem_select_o),
    .mem_load_o(mem_load_o), .mem_store_o(mem_store_o),
    .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    core_addr_i = '0; core_data_i = '0; core_select_i = 4'hF;
    core_load_i = 1'b0; core_store_i = 1'b0;
    ext_addr_i = '0; ext_data_i = '0; ext_select_i = 4'hF; ext_we_i = 1'b0; ext_req_i = 1'b0;
    mem_ready_i = 1'b0; mem_data_i = '0;

    // reset state
    nxt(); nxt(); #1;
    chk("rst_mem_load", mem_load_o, 0);
    chk("rst_mem_store", mem_store_o, 0);
    chk("rst_core_ready", core_ready_o, 1);
    chk("rst_ext_ack", ext_ack_o, 0);
    chk("rst_errs", {core_err_o, ext_err_o}, 0);

    // core load, zero latency
    nxt(); rst_i = 1'b0;
    core_load_i = 1'b1; core_addr_i = 32'h40; mem_ready_i = 1'b1; mem_data_i = 32'h12345678; #1;
    chk("ld_mem_load", mem_load_o, 1);
    chk("ld_mem_addr", mem_addr_o, 32'h40);
    chk("ld_core_ready", core_ready_o, 1);
    chk("ld_core_data", core_data_o, 32'h12345678);

    // load+store together: load wins
    nxt(); core_store_i = 1'b1; #1;
    chk("ldst_load", mem_load_o, 1);
    chk("ldst_store", mem_store_o, 0);

    // core store stalled 3 cycles, request dropped after cycle 1
    nxt(); core_load_i = 1'b0; core_store_i = 1'b1; core_addr_i = 32'h80;
    core_data_i = 32'hA5A5_0001; core_select_i = 4'hC; mem_ready_i = 1'b0; #1;
    chk("st1_store", mem_store_o, 1);
    chk("st1_ready", core_ready_o, 0);
    nxt(); core_store_i = 1'b0; core_addr_i = 32'h0; core_data_i = 32'h0; core_select_i = 4'h0; #1;
    chk("st2_store", mem_store_o, 1);
    chk("st2_addr", mem_addr_o, 32'h80);
    chk("st2_data", mem_data_o, 32'hA5A5_0001);
    chk("st2_sel", mem_select_o, 4'hC);
    chk("st2_ready", core_ready_o, 0);
    nxt(); #1;
    chk("st3_store", mem_store_o, 1);
    chk("st3_ready", core_ready_o, 0);
    nxt(); mem_ready_i = 1'b1; #1;
    chk("st4_store", mem_store_o, 1);
    chk("st4_ready", core_ready_o, 1);
    chk("st4_err", core_err_o, 0);
    nxt(); mem_ready_i = 1'b0; #1;
    chk("st5_idle_store", mem_store_o, 0);
    chk("st5_idle_ready", core_ready_o, 1);

    // ext read at 0x100, idle core
    nxt(); ext_req_i = 1'b1; ext_we_i = 1'b0; ext_addr_i = 32'h100; #1;
    chk("ext1_no_load", mem_load_o, 0);
    nxt(); #1;
    chk("ext2_load", mem_load_o, 1);
    chk("ext2_addr", mem_addr_o, 32'h100);
    chk("ext2_core_ready", core_ready_o, 0);
    chk("ext2_ack", ext_ack_o, 0);
    nxt(); mem_ready_i = 1'b1; mem_data_i = 32'hCAFEF00D; #1;
    chk("ext3_ack", ext_ack_o, 1);
    chk("ext3_data", ext_data_o, 32'hCAFEF00D);
    chk("ext3_err", ext_err_o, 0);
    nxt(); ext_req_i = 1'b0; mem_ready_i = 1'b0; #1;
    chk("ext4_ack", ext_ack_o, 0);
    chk("ext4_idle", {mem_load_o, core_ready_o}, 2'b01);

    // starvation: core loads every cycle, ext write waits exactly 8 cycles
    nxt(); core_load_i = 1'b1; core_addr_i = 32'h44; mem_ready_i = 1'b1;
    ext_req_i = 1'b1; ext_we_i = 1'b1; ext_addr_i = 32'h200; ext_data_i = 32'h55; #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin nxt(); #1; end
      chk($sformatf("stv_core_%0d", i), {core_ready_o, mem_load_o, mem_store_o}, 3'b110);
    end
    nxt(); #1;
    chk("stv_grant", {core_ready_o, mem_load_o, mem_store_o}, 3'b000);
    nxt(); mem_ready_i = 1'b0; #1;
    chk("stv_ext_store", mem_store_o, 1);
    chk("stv_ext_addr", mem_addr_o, 32'h200);
    chk("stv_ext_data", mem_data_o, 32'h55);
    chk("stv_ext_core_ready", core_ready_o, 0);
    nxt(); mem_ready_i = 1'b1; #1;
    chk("stv_ack", ext_ack_o, 1);
    chk("stv_ack_core_ready", core_ready_o, 0);
    nxt(); ext_req_i = 1'b0; #1;
    chk("stv_core_back", {core_ready_o, mem_load_o}, 2'b11);

    // core load timeout after 4 cycles
    nxt(); core_addr_i = 32'h300; mem_ready_i = 1'b0; mem_data_i = 32'h0; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin nxt(); #1; end
      chk($sformatf("tmo_wait_%0d", i), {core_ready_o, core_err_o, mem_load_o}, 3'b001);
    end
    nxt(); #1;
    chk("tmo_ready_err", {core_ready_o, core_err_o}, 2'b11);
    chk("tmo_data", core_data_o, 32'hDEADBEEF);
    chk("tmo_mem_dropped", mem_load_o, 0);
    nxt(); core_load_i = 1'b0; #1;
    chk("tmo_idle", {core_ready_o, core_err_o, mem_load_o}, 3'b100);

    // ext read timeout: grant cycle, then abort on the 4th EXT cycle
    nxt(); ext_req_i = 1'b1; ext_we_i = 1'b0; ext_addr_i = 32'h140; #1;
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk($sformatf("etmo_wait_%0d", i), {ext_ack_o, mem_load_o}, 2'b01);
    end
    nxt(); #1;
    chk("etmo_ack_err", {ext_ack_o, ext_err_o}, 2'b11);
    chk("etmo_data", ext_data_o, 32'hDEADBEEF);
    chk("etmo_mem_dropped", mem_load_o, 0);
    nxt(); ext_req_i = 1'b0; #1;
    chk("etmo_idle", {ext_ack_o, core_ready_o}, 2'b01);

    // reset while in EXT discards the access
    nxt(); ext_req_i = 1'b1; ext_addr_i = 32'h400; #1;
    nxt(); #1;
    chk("rext_load", mem_load_o, 1);
    nxt(); rst_i = 1'b1; ext_req_i = 1'b0; #1;
    nxt(); rst_i = 1'b0; mem_ready_i = 1'b1; #1;
    chk("rext_idle", {mem_load_o, mem_store_o, ext_ack_o, core_ready_o}, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk($sformatf("rext_no_ack_%0d", i), {ext_ack_o, mem_load_o}, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
